plot_cmd_framer: RTL and testbench

Pop-side controller for the byte FIFO that buffers host-to-plotter UART traffic. It sequences FIFO pops, hunts for frame headers and assembles 7-byte command frames. It validates the opcode and XOR checksum, then hands decoded move/draw/home commands to the motion planner over a valid/ready handshake. Bad or stalled frames are dropped, error pulses are raised, and the block resyncs on the next header.

---
 rtl/plot_pkg.sv | 27 ++
 rtl/plot_byte_timer.sv | 28 ++
 rtl/plot_cmd_framer.sv | 191 +++++++++++++++++++
 tb/tb_plot_cmd_framer.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plot_pkg.sv
// Shared types and constants for the host-to-plotter command path.
// Used by the frame assembler and its inter-byte timer.
package plot_pkg;

    typedef enum logic [1:0] {
        OP_MOVE = 2'd1,
        OP_DRAW = 2'd2,
        OP_HOME = 2'd3
    } plot_op_t;

    typedef enum logic [1:0] {
        HUNT,
        COLLECT,
        CHECK,
        OUTPUT
    } framer_state_t;

    localparam int         FRAME_LEN      = 7;
    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    function automatic logic op_is_valid(input logic [7:0] op);
        return (op == 8'(OP_MOVE)) ||
               (op == 8'(OP_DRAW)) ||
               (op == 8'(OP_HOME));
    endfunction

endpackage

// File: rtl/plot_byte_timer.sv
// Inter-byte watchdog: clearable, enabled up-counter that
// saturates and flags terminal count at TIMEOUT_CYC.
module plot_byte_timer #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TC_VAL = TO_W'(TIMEOUT_CYC);

    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_tc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/plot_cmd_framer.sv
// Pops the UART byte FIFO, assembles 7-byte command frames, checks
// opcode and XOR checksum, and hands commands to the motion planner.
module plot_cmd_framer
    import plot_pkg::*;
#(
    parameter logic [7:0] HEADER      = DEFAULT_HEADER,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        fifo_pop,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [1:0]  cmd_op,
    output logic [15:0] cmd_x,
    output logic [15:0] cmd_y,
    output logic        err_chk,
    output logic        err_op,
    output logic        err_tmo,
    output logic        busy
);

    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

    framer_state_t r_state;
    framer_state_t w_state_nxt;

    logic        r_pend;
    logic [2:0]  r_idx;
    logic [7:0]  r_acc;
    logic [7:0]  r_op;
    logic [7:0]  r_xh;
    logic [7:0]  r_xl;
    logic [7:0]  r_yh;
    logic [7:0]  r_yl;
    logic [7:0]  r_chk;
    logic        r_cmd_valid;
    logic [1:0]  r_cmd_op;
    logic [15:0] r_cmd_x;
    logic [15:0] r_cmd_y;
    logic        r_err_chk;
    logic        r_err_op;
    logic        r_err_tmo;

    logic w_pop;
    logic w_hdr;
    logic w_store;
    logic w_tmo;
    logic w_chk_bad;
    logic w_op_bad;
    logic w_load;
    logic w_tc;
    logic w_is_hdr;

    assign w_is_hdr = r_pend && (fifo_data == HEADER);

    plot_byte_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .i_clr((r_state != COLLECT) || r_pend),
        .i_en (r_state == COLLECT),
        .o_tc (w_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_hdr       = 1'b0;
        w_store     = 1'b0;
        w_tmo       = 1'b0;
        w_chk_bad   = 1'b0;
        w_op_bad    = 1'b0;
        w_load      = 1'b0;
        unique case (r_state)
            HUNT: begin
                w_pop = !r_pend && !fifo_empty;
                if (w_is_hdr) begin
                    w_hdr       = 1'b1;
                    w_state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (w_tc) begin
                    // A byte landing on the timeout cycle is judged as a HUNT byte.
                    w_tmo       = 1'b1;
                    w_hdr       = w_is_hdr;
                    w_state_nxt = w_is_hdr ? COLLECT : HUNT;
                end else begin
                    w_pop   = !r_pend && !fifo_empty;
                    w_store = r_pend;
                    if (r_pend && (r_idx == LAST_IDX)) begin
                        w_state_nxt = CHECK;
                    end
                end
            end
            CHECK: begin
                if (r_acc != r_chk) begin
                    w_chk_bad   = 1'b1;
                    w_state_nxt = HUNT;
                end else if (!op_is_valid(r_op)) begin
                    w_op_bad    = 1'b1;
                    w_state_nxt = HUNT;
                end else begin
                    w_load      = 1'b1;
                    w_state_nxt = OUTPUT;
                end
            end
            OUTPUT: begin
                if (r_cmd_valid && cmd_ready) begin
                    w_state_nxt = HUNT;
                end
            end
            default: w_state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend      <= 1'b0;
            r_idx       <= '0;
            r_acc       <= '0;
            r_op        <= '0;
            r_xh        <= '0;
            r_xl        <= '0;
            r_yh        <= '0;
            r_yl        <= '0;
            r_chk       <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_op    <= '0;
            r_cmd_x     <= '0;
            r_cmd_y     <= '0;
            r_err_chk   <= 1'b0;
            r_err_op    <= 1'b0;
            r_err_tmo   <= 1'b0;
        end else begin
            r_pend    <= w_pop;
            r_err_chk <= w_chk_bad;
            r_err_op  <= w_op_bad;
            r_err_tmo <= w_tmo;
            if (w_hdr) begin
                r_idx <= 3'd1;
                r_acc <= '0;
            end else if (w_store) begin
                r_idx <= r_idx + 3'd1;
                if (r_idx != LAST_IDX) begin
                    r_acc <= r_acc ^ fifo_data;
                end
                unique case (r_idx)
                    3'd1:    r_op  <= fifo_data;
                    3'd2:    r_xh  <= fifo_data;
                    3'd3:    r_xl  <= fifo_data;
                    3'd4:    r_yh  <= fifo_data;
                    3'd5:    r_yl  <= fifo_data;
                    3'd6:    r_chk <= fifo_data;
                    default: ;
                endcase
            end
            if (w_load) begin
                r_cmd_valid <= 1'b1;
                r_cmd_op    <= r_op[1:0];
                r_cmd_x     <= {r_xh, r_xl};
                r_cmd_y     <= {r_yh, r_yl};
            end else if (r_cmd_valid && cmd_ready) begin
                r_cmd_valid <= 1'b0;
            end
        end
    end

    assign fifo_pop  = w_pop && !reset;
    assign cmd_valid = r_cmd_valid;
    assign cmd_op    = r_cmd_op;
    assign cmd_x     = r_cmd_x;
    assign cmd_y     = r_cmd_y;
    assign err_chk   = r_err_chk;
    assign err_op    = r_err_op;
    assign err_tmo   = r_err_tmo;
    assign busy      = (r_state != HUNT) || r_pend;

endmodule

// File: tb/tb_plot_cmd_framer.sv
// Bench for plot_cmd_framer: vector table, corner sequences and
// a randomized byte stream judged by a frame-level parser model.
module tb_plot_cmd_framer;

    localparam int         TMO = 16;
    localparam logic [7:0] HDR = 8'hA5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fifo_empty;
    logic [7:0]  fifo_data = '0;
    logic        fifo_pop;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_x;
    logic [15:0] cmd_y;
    logic        err_chk;
    logic        err_op;
    logic        err_tmo;
    logic        busy;

    plot_cmd_framer #(
        .HEADER     (HDR),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_pop  (fifo_pop),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .err_chk   (err_chk),
        .err_op    (err_op),
        .err_tmo   (err_tmo),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Byte FIFO with registered read data
    logic [7:0] mem [4096];
    int wp = 0;
    int rp = 0;
    assign fifo_empty = (rp == wp);

    always @(posedge clk) begin
        if (fifo_pop && (rp != wp)) begin
            fifo_data <= mem[rp % 4096];
            rp <= rp + 1;
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wp % 4096] = b;
        wp++;
    endtask

    typedef struct packed {
        logic [1:0]  op;
        logic [15:0] x;
        logic [15:0] y;
    } cmd_t;

    cmd_t got_q[$];
    int n_chk_seen = 0;
    int n_op_seen  = 0;
    int n_tmo_seen = 0;
    int cyc        = 0;
    int last_pop   = 0;

    initial begin
        logic pv = 1'b0, pr = 1'b0, ppop = 1'b0, prst = 1'b1;
        logic pe_chk = 1'b0, pe_op = 1'b0, pe_tmo = 1'b0;
        cmd_t pcmd = '0;
        cmd_t c;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset && !prst) begin
                if (fifo_pop) begin
                    check("pop_when_empty", fifo_empty, 0);
                    check("pop_back_to_back", ppop, 0);
                    check("pop_in_output", cmd_valid, 0);
                    last_pop = cyc;
                end
                if (pv && !pr) begin
                    check("hold_valid", cmd_valid, 1);
                    check("hold_cmd", {cmd_op, cmd_x, cmd_y} == pcmd, 1);
                end
                if (err_chk || err_op || err_tmo) begin
                    check("err_onehot",
                          32'(err_chk) + 32'(err_op) + 32'(err_tmo), 1);
                    check("err_pulse_len",
                          (err_chk && pe_chk) || (err_op && pe_op) ||
                          (err_tmo && pe_tmo), 0);
                end
                if (err_tmo) begin
                    check("tmo_gap_lo", (cyc - last_pop) >= TMO + 2, 1);
                    check("tmo_gap_hi", (cyc - last_pop) <= TMO + 4, 1);
                end
                if (cmd_valid && cmd_ready) begin
                    c = {cmd_op, cmd_x, cmd_y};
                    got_q.push_back(c);
                end
                n_chk_seen += 32'(err_chk);
                n_op_seen  += 32'(err_op);
                n_tmo_seen += 32'(err_tmo);
            end
            pv     = cmd_valid;
            pr     = cmd_ready;
            ppop   = fifo_pop;
            prst   = reset;
            pe_chk = err_chk;
            pe_op  = err_op;
            pe_tmo = err_tmo;
            pcmd   = {cmd_op, cmd_x, cmd_y};
        end
    end

    bit rnd_ready = 1'b0;
    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_ready) cmd_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drain();
        int n = 0;
        while ((rp != wp || busy || cmd_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_bound", n < 3000, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic sync_in();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_pop"}, fifo_pop, 0);
        check({tag, "_valid"}, cmd_valid, 0);
        check({tag, "_op"}, 32'(cmd_op), 0);
        check({tag, "_x"}, 32'(cmd_x), 0);
        check({tag, "_y"}, 32'(cmd_y), 0);
        check({tag, "_errs"}, {err_chk, err_op, err_tmo}, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    typedef struct {
        logic [79:0] b;
        int          len;
        int          n_cmd;
        logic [1:0]  op;
        logic [15:0] x;
        logic [15:0] y;
        int          n_chk;
        int          n_op;
        int          n_tmo;
    } vec_t;

    vec_t vecs [10];

    task automatic run_vec(input vec_t v, input int k);
        int base = got_q.size();
        int c0 = n_chk_seen, o0 = n_op_seen, t0 = n_tmo_seen;
        sync_in();
        for (int i = 0; i < v.len; i++) push(v.b[79 - 8 * i -: 8]);
        drain();
        check($sformatf("v%0d_ncmd", k), got_q.size() - base, v.n_cmd);
        if (v.n_cmd == 1 && got_q.size() > base) begin
            check($sformatf("v%0d_op", k), 32'(got_q[base].op), 32'(v.op));
            check($sformatf("v%0d_x", k), 32'(got_q[base].x), 32'(v.x));
            check($sformatf("v%0d_y", k), 32'(got_q[base].y), 32'(v.y));
        end
        check($sformatf("v%0d_errchk", k), n_chk_seen - c0, v.n_chk);
        check($sformatf("v%0d_errop", k), n_op_seen - o0, v.n_op);
        check($sformatf("v%0d_errtmo", k), n_tmo_seen - t0, v.n_tmo);
    endtask

    logic [7:0] stim_q[$];
    cmd_t       exp_q[$];

    // Frame parser over the whole byte stream
    task automatic model(output int ec, output int eo, output int et);
        int i = 0;
        logic [7:0] x;
        cmd_t c;
        exp_q.delete();
        ec = 0;
        eo = 0;
        et = 0;
        while (i < stim_q.size()) begin
            if (stim_q[i] != HDR) begin
                i++;
            end else if (i + 6 >= stim_q.size()) begin
                et = 1;
                i = stim_q.size();
            end else begin
                x = 8'h00;
                for (int k = 1; k <= 5; k++) x = x ^ stim_q[i + k];
                if (x != stim_q[i + 6]) begin
                    ec++;
                end else if (stim_q[i + 1] == 0 || stim_q[i + 1] > 3) begin
                    eo++;
                end else begin
                    c.op = stim_q[i + 1][1:0];
                    c.x  = {stim_q[i + 2], stim_q[i + 3]};
                    c.y  = {stim_q[i + 4], stim_q[i + 5]};
                    exp_q.push_back(c);
                end
                i += 7;
            end
        end
    endtask

    task automatic gen_round(input bit partial);
        logic [7:0] f [7];
        int kind;
        stim_q.delete();
        for (int n = 0; n < 12; n++) begin
            kind = $urandom_range(0, 5);
            if (kind == 0) begin
                for (int g = 0; g < $urandom_range(1, 3); g++)
                    stim_q.push_back(8'($urandom_range(0, 255)));
            end else begin
                f[0] = HDR;
                if (kind == 5)
                    f[1] = $urandom_range(0, 1) ? 8'h00 : 8'($urandom_range(4, 255));
                else
                    f[1] = 8'($urandom_range(1, 3));
                for (int k = 2; k <= 5; k++) f[k] = 8'($urandom_range(0, 255));
                f[6] = f[1] ^ f[2] ^ f[3] ^ f[4] ^ f[5];
                if (kind == 4) f[6] = f[6] ^ 8'($urandom_range(1, 255));
                for (int k = 0; k < 7; k++) stim_q.push_back(f[k]);
            end
        end
        if (partial) begin
            stim_q.push_back(HDR);
            for (int k = 0; k < $urandom_range(0, 4); k++)
                stim_q.push_back(8'($urandom_range(0, 255)));
        end
    endtask

    initial begin
        int base, c0, o0, t0, n, ec, eo, et;

        vecs[0] = '{80'hA5_02_01_23_04_56_72_00_00_00, 7, 1, 2'd2, 16'h0123, 16'h0456, 0, 0, 0};
        vecs[1] = '{80'h00_FF_A5_03_00_00_00_00_03_00, 9, 1, 2'd3, 16'h0000, 16'h0000, 0, 0, 0};
        vecs[2] = '{80'hA5_01_10_00_20_00_00_00_00_00, 7, 0, 2'd0, 16'h0000, 16'h0000, 1, 0, 0};
        vecs[3] = '{80'hA5_07_00_00_00_00_07_00_00_00, 7, 0, 2'd0, 16'h0000, 16'h0000, 0, 1, 0};
        vecs[4] = '{80'hA5_09_00_00_00_00_00_00_00_00, 7, 0, 2'd0, 16'h0000, 16'h0000, 1, 0, 0};
        vecs[5] = '{80'hA5_00_00_00_00_00_00_00_00_00, 7, 0, 2'd0, 16'h0000, 16'h0000, 0, 1, 0};
        vecs[6] = '{80'hA5_01_FF_FF_00_00_01_00_00_00, 7, 1, 2'd1, 16'hFFFF, 16'h0000, 0, 0, 0};
        vecs[7] = '{80'hA5_03_A5_00_A5_00_03_00_00_00, 7, 1, 2'd3, 16'hA500, 16'hA500, 0, 0, 0};
        vecs[8] = '{80'hA5_01_12_00_00_00_00_00_00_00, 3, 0, 2'd0, 16'h0000, 16'h0000, 0, 0, 1};
        vecs[9] = '{80'h11_22_33_00_00_00_00_00_00_00, 3, 0, 2'd0, 16'h0000, 16'h0000, 0, 0, 0};

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset = 1'b0;
        cmd_ready = 1'b1;

        for (int k = 0; k < 10; k++) run_vec(vecs[k], k);

        // Back-pressure: hold ready low 20 cycles with a second frame queued
        base = got_q.size();
        sync_in();
        cmd_ready = 1'b0;
        for (int i = 0; i < 7; i++) push(vecs[0].b[79 - 8 * i -: 8]);
        push(HDR); push(8'h01); push(8'h00); push(8'h10);
        push(8'h00); push(8'h20); push(8'h31);
        n = 0;
        while (!cmd_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", n < 200, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_valid", cmd_valid, 1);
            check("bp_cmd", {cmd_op, cmd_x, cmd_y}, {2'd2, 16'h0123, 16'h0456});
            check("bp_nopop", fifo_pop, 0);
        end
        sync_in();
        cmd_ready = 1'b1;
        drain();
        check("bp_ncmd", got_q.size() - base, 2);
        if (got_q.size() >= base + 2) begin
            check("bp_second", got_q[base + 1], {2'd1, 16'h0010, 16'h0020});
        end

        // Reset in the middle of a frame
        base = got_q.size();
        c0 = n_chk_seen; o0 = n_op_seen; t0 = n_tmo_seen;
        sync_in();
        push(HDR); push(8'h01); push(8'h12);
        n = 0;
        while (rp != wp && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        sync_in();
        reset = 1'b1;
        sync_in();
        check_idle_outputs("midrst");
        reset = 1'b0;
        push(8'h34); push(8'h00); push(8'h56); push(8'h71);
        drain();
        check("midrst_ncmd", got_q.size() - base, 0);
        check("midrst_errs", (n_chk_seen - c0) + (n_op_seen - o0) + (n_tmo_seen - t0), 0);

        // Randomized streams with random back-pressure
        rnd_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            gen_round(r[0]);
            model(ec, eo, et);
            base = got_q.size();
            c0 = n_chk_seen; o0 = n_op_seen; t0 = n_tmo_seen;
            sync_in();
            foreach (stim_q[i]) push(stim_q[i]);
            drain();
            check($sformatf("rnd%0d_ncmd", r), got_q.size() - base, exp_q.size());
            for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
                check($sformatf("rnd%0d_cmd%0d", r, i), got_q[base + i] == exp_q[i], 1);
            end
            check($sformatf("rnd%0d_errchk", r), n_chk_seen - c0, ec);
            check($sformatf("rnd%0d_errop", r), n_op_seen - o0, eo);
            check($sformatf("rnd%0d_errtmo", r), n_tmo_seen - t0, et);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
